// File: rtl/ram_burst_master.sv
// ram_burst_master
//   Initiator-side burst controller for the single-port RAM (ram_simple).
//   Accepts write/read burst commands, streams write beats into the RAM and
//   streams RAM contents out on a back-pressured read channel. It is the only
//   driver of the RAM port.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          burst command handshake
//   cmd_write, cmd_addr, cmd_len command fields (beats = cmd_len + 1)
//   wr_valid/wr_ready, wr_data   write beat channel
//   rd_valid/rd_ready, rd_data   read beat channel, rd_last flags final beat
//   busy                         high whenever the FSM is not IDLE
//   done                         one-cycle pulse when a burst completes
//   mem_we, mem_addr, mem_wdata  registered RAM command outputs
//   mem_rdata                    RAM registered read data (mem[mem_addr] at previous edge)
//
// Handshake semantics (all channels): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid high keeps its
// payload stable until the transfer; ready may change freely while valid is low.
module ram_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH:0]    LEN_ONE  = (LEN_WIDTH + 1)'(1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [LEN_WIDTH:0]      beats_left;      // beats still to complete (accept or pop)
  logic [LEN_WIDTH:0]      beats_to_issue;  // read beats not yet issued to the RAM

  // Read FIFO (4 entries) and the two-stage in-flight tracker:
  // pipe_s1 = address issued last edge, RAM samples it at the next edge;
  // pipe_s2 = mem_rdata now holds that beat, captured at the next edge.
  logic [DATA_WIDTH-1:0]   fifo_mem [4];
  logic [1:0]              fifo_wr_ptr;
  logic [1:0]              fifo_rd_ptr;
  logic [2:0]              fifo_count;
  logic                    pipe_s1;
  logic                    pipe_s2;
  logic [3:0]              occupancy;
  logic                    issue;
  logic                    push;
  logic                    pop;

  // Issue is throttled on FIFO entries plus beats still in flight, so every
  // issued beat is guaranteed a slot when it lands; no pop credit is taken.
  assign occupancy = {1'b0, fifo_count} + {3'b000, pipe_s1} + {3'b000, pipe_s2};
  assign issue     = (state == READ) && (beats_to_issue != '0) && (occupancy < 4'd4);
  assign push      = pipe_s2;
  assign pop       = rd_valid && rd_ready;

  assign rd_valid  = (fifo_count != 3'd0);
  assign rd_data   = fifo_mem[fifo_rd_ptr];
  // beats_left counts unpopped read beats, so the head is final when it is 1.
  assign rd_last   = rd_valid && (beats_left == LEN_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cmd_ready      <= 1'b1;
      wr_ready       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      cur_addr       <= '0;
      beats_left     <= '0;
      beats_to_issue <= '0;
      fifo_wr_ptr    <= 2'd0;
      fifo_rd_ptr    <= 2'd0;
      fifo_count     <= 3'd0;
      pipe_s1        <= 1'b0;
      pipe_s2        <= 1'b0;
    end else begin
      done    <= 1'b0;
      pipe_s1 <= issue;
      pipe_s2 <= pipe_s1;

      if (push) begin
        fifo_mem[fifo_wr_ptr] <= mem_rdata;
        fifo_wr_ptr           <= fifo_wr_ptr + 2'd1;
      end
      if (pop) begin
        fifo_rd_ptr <= fifo_rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase

      if (issue) begin
        mem_addr       <= cur_addr;
        cur_addr       <= cur_addr + ADDR_ONE;
        beats_to_issue <= beats_to_issue - LEN_ONE;
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cur_addr       <= cmd_addr;
            beats_left     <= {1'b0, cmd_len} + LEN_ONE;
            beats_to_issue <= {1'b0, cmd_len} + LEN_ONE;
            cmd_ready      <= 1'b0;
            busy           <= 1'b1;
            if (cmd_write) begin
              state    <= WRITE;
              wr_ready <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          if (wr_valid && wr_ready) begin
            mem_we     <= 1'b1;
            mem_addr   <= cur_addr;
            mem_wdata  <= wr_data;
            cur_addr   <= cur_addr + ADDR_ONE;
            beats_left <= beats_left - LEN_ONE;
            if (beats_left == LEN_ONE) begin
              state    <= FINISH;
              wr_ready <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            mem_we <= 1'b0;
          end
        end
        READ: begin
          if (pop) begin
            beats_left <= beats_left - LEN_ONE;
            if (beats_left == LEN_ONE) begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        FINISH: begin
          mem_we    <= 1'b0;
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator-side controller for the team's single-port RAM (`ram_simple`: one clock, `we`, `addr`, `data_in`, `data_out`).
- Accepts burst commands over a valid/ready handshake.
- Write bursts: streams data from a write channel into the RAM.
- Read bursts: streams RAM contents out on a back-pressured read channel.
- Sits between DMA/test logic and the RAM; it is the only driver of the RAM port.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- LEN_WIDTH, 4, burst length field width; burst beats = cmd_len+1 (1..2^LEN_WIDTH).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller idle, command accepted when cmd_valid&cmd_ready.
- cmd_write  input  1  1=write burst, 0=read burst.
- cmd_addr  input  ADDR_WIDTH  burst start address.
- cmd_len  input  LEN_WIDTH  beats minus one.
- wr_valid  input  1  write beat offered.
- wr_ready  output  1  write beat accepted when wr_valid&wr_ready.
- wr_data  input  DATA_WIDTH  write beat data.
- rd_valid  output  1  read beat available.
- rd_ready  input  1  consumer accepts read beat.
- rd_data  output  DATA_WIDTH  read beat data.
- rd_last  output  1  marks final beat of the read burst.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a burst completes.
- mem_we  output  1  RAM write enable (registered).
- mem_addr  output  ADDR_WIDTH  RAM address (registered).
- mem_wdata  output  DATA_WIDTH  RAM write data (registered).
- mem_rdata  input  DATA_WIDTH  RAM registered read data: value of mem[mem_addr] sampled at the previous edge.

Behaviour:

Reset:
- Reset is synchronous and active-high, on rst.
- Reset applies in all states and mid-burst.
- Reset values: state=IDLE, cmd_ready=1, wr_ready=0, rd_valid=0, rd_last=0, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset flushes the read FIFO and the in-flight pipeline. The aborted burst produces no done pulse.

FSM states: IDLE, WRITE, READ, FINISH.

IDLE:
- cmd_ready=1.
- On handshake: latch cur_addr=cmd_addr and beats_left=cmd_len+1 (width LEN_WIDTH+1).
- Go to WRITE if cmd_write, else READ.
- cmd_ready=0 in every other state; cmd_valid is ignored while busy.

WRITE:
- wr_ready=1.
- Each accepted beat at edge k sets, at the same edge: mem_we=1, mem_addr=cur_addr, mem_wdata=wr_data. The RAM commits at edge k+1.
- cur_addr increments; beats_left decrements.
- A cycle with no accepted beat forces mem_we=0 at the next edge.
- When the last beat is accepted, go to FINISH. mem_we is deasserted at the following edge.

READ:
- 4-entry read FIFO plus a 2-stage in-flight tracker (issue -> RAM sample -> capture).
- Issue is allowed when beats_to_issue>0 and fifo_count+inflight<4.
- An issue at edge k sets mem_addr=cur_addr and increments cur_addr.
- mem_rdata is captured into the FIFO at edge k+2.
- mem_we stays 0 throughout READ.
- rd_valid = FIFO non-empty; rd_data = FIFO head.
- rd_last=1 on the head entry exactly when it is the final beat of the burst.
- Pop on rd_valid&rd_ready. Simultaneous push and pop keeps count unchanged.
- With rd_ready held high: first rd_valid appears 3 cycles after the command handshake, then 1 beat/cycle.
- The FIFO never overflows; issue stalls instead.
- When the final beat is popped, go to FINISH.

FINISH:
- done=1 for exactly one cycle, then IDLE. cmd_ready rises on the cycle after done.

Address arithmetic:
- Modulo 2^ADDR_WIDTH; address 2^ADDR_WIDTH-1 is followed by 0.
- No error signal on wrap.

Other rules:
- wr_valid is ignored outside WRITE.
- rd_ready is a don't-care when rd_valid=0.
- rd_data and rd_last must stay stable while rd_valid=1 and rd_ready=0.
- mem_addr holds its last value when idle.

Test Plan:
- Write then read:
  - Stimulus: write burst addr=0x10, len=3, data 0xA1,0xB2,0xC3,0xD4 with wr_valid held; then read burst addr=0x10, len=3 with rd_ready=1.
  - Required: mem_we high for 4 consecutive cycles at addrs 0x10..0x13; read returns A1,B2,C3,D4 on consecutive cycles; rd_last on D4; one done pulse per burst.
- Address wrap:
  - Stimulus: write addr=0xFE, len=3, data 1,2,3,4; read back from 0xFE.
  - Required: addresses 0xFE,0xFF,0x00,0x01 receive 1,2,3,4; read returns 1,2,3,4.
- Read back-pressure:
  - Stimulus: read len=7 with rd_ready low for 10 cycles after the first rd_valid.
  - Required: at most 4 entries buffered; no issue while fifo_count+inflight=4; rd_data held stable; all 8 beats delivered in order after release.
- Write stalls:
  - Stimulus: write len=2, wr_valid toggled 1,0,0,1,0,1.
  - Required: mem_we pulses exactly 3 times with the correct data and addresses; done only after the 3rd beat.
- Command blocking:
  - Stimulus: cmd_valid held high during an active read burst.
  - Required: cmd_ready=0 until the cycle after done; the second command is accepted only then.
- Reset mid-burst:
  - Stimulus: rst asserted one cycle during a len=15 read after 5 beats.
  - Required: next cycle rd_valid=0, mem_we=0, cmd_ready=1, busy=0, no done pulse; a subsequent burst operates normally.
